// File: rtl/parallel_fitness_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : parallel_fitness_dispatcher_if
// Description : Request, result and evaluator-lane buses of the fitness
//               dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface parallel_fitness_dispatcher_if #(
    parameter int IndividualWidth = 64,
    parameter int ErrorWidth      = 5,
    parameter int Lanes           = 4
);
    logic                               inValid;
    logic                               inReady;
    logic [IndividualWidth-1:0]         inIndividual;
    logic                               outValid;
    logic [IndividualWidth-1:0]         outIndividual;
    logic [ErrorWidth-1:0]              outError;
    logic [Lanes-1:0]                   laneStart;
    logic [Lanes*IndividualWidth-1:0]   laneIndividual;
    logic [Lanes-1:0]                   laneFinish;
    logic [Lanes*ErrorWidth-1:0]        laneError;

    modport slave (
        input  inValid, inIndividual, laneFinish, laneError,
        output inReady, outValid, outIndividual, outError, laneStart, laneIndividual
    );

    modport master (
        output inValid, inIndividual, laneFinish, laneError,
        input  inReady, outValid, outIndividual, outError, laneStart, laneIndividual
    );
endinterface
`default_nettype wire

// File: rtl/parallel_fitness_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : parallel_fitness_dispatcher
// Description : Dispatches individuals to parallel fitness lanes and emits
//               results in acceptance order with best/generation tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_fitness_dispatcher #(
    parameter int IndividualWidth = 64,
    parameter int ErrorWidth      = 5,
    parameter int Lanes           = 4,
    parameter int GenerationSize  = 16,
    parameter int GenerationWidth = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          enable,
    input  wire logic [ErrorWidth-1:0]         targetError,
    parallel_fitness_dispatcher_if.slave       bus,
    output logic      [IndividualWidth-1:0]    bestIndividual,
    output logic      [ErrorWidth-1:0]         bestError,
    output logic      [GenerationWidth-1:0]    generation,
    output logic                               done,
    output logic                               busy
);
    localparam int IdxW = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int CntW = $clog2(GenerationSize);

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_RUN  = 2'd1,
        LANE_HELD = 2'd2
    } lane_state_e;

    lane_state_e                state_q [Lanes];
    lane_state_e                state_d [Lanes];
    logic [IndividualWidth-1:0] ind_q   [Lanes];
    logic [IndividualWidth-1:0] ind_d   [Lanes];
    logic [ErrorWidth-1:0]      err_q   [Lanes];
    logic [ErrorWidth-1:0]      err_d   [Lanes];
    logic [IdxW-1:0]            ord_q   [Lanes];
    logic [IdxW-1:0]            ord_d   [Lanes];

    logic [IdxW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [IdxW:0]              cnt_q, cnt_d;
    logic [Lanes-1:0]           laneStart_q, laneStart_d;
    logic                       outValid_q, outValid_d;
    logic [IndividualWidth-1:0] outInd_q, outInd_d;
    logic [ErrorWidth-1:0]      outErr_q, outErr_d;
    logic [IndividualWidth-1:0] bestInd_q, bestInd_d;
    logic [ErrorWidth-1:0]      bestErr_q, bestErr_d;
    logic [GenerationWidth-1:0] gen_q, gen_d;
    logic [CntW-1:0]            emitCnt_q, emitCnt_d;
    logic                       done_q, done_d;

    logic                       anyIdle;
    logic [IdxW-1:0]            freeIdx;
    logic                       accept;
    logic [IdxW-1:0]            headLane;
    logic                       emit;
    logic [ErrorWidth-1:0]      headErr;

    always_comb begin
        anyIdle = 1'b0;
        freeIdx = '0;
        for (int i = Lanes - 1; i >= 0; i--) begin
            if (state_q[i] == LANE_IDLE) begin
                anyIdle = 1'b1;
                freeIdx = IdxW'(i);
            end
        end
    end

    assign bus.inReady = enable && !done_q && anyIdle;
    assign accept      = bus.inValid && bus.inReady;
    assign headLane    = ord_q[head_q];

    // A head lane finishing on this very edge is emitted directly, bypassing HELD.
    always_comb begin
        emit    = 1'b0;
        headErr = err_q[headLane];
        if (cnt_q != '0) begin
            if (state_q[headLane] == LANE_HELD) begin
                emit = 1'b1;
            end else if (state_q[headLane] == LANE_RUN && bus.laneFinish[headLane]) begin
                emit    = 1'b1;
                headErr = bus.laneError[int'(headLane)*ErrorWidth +: ErrorWidth];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ind_d       = ind_q;
        err_d       = err_q;
        ord_d       = ord_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        laneStart_d = '0;
        outValid_d  = 1'b0;
        outInd_d    = outInd_q;
        outErr_d    = outErr_q;
        bestInd_d   = bestInd_q;
        bestErr_d   = bestErr_q;
        gen_d       = gen_q;
        emitCnt_d   = emitCnt_q;
        done_d      = done_q;

        for (int i = 0; i < Lanes; i++) begin
            if (state_q[i] == LANE_RUN && bus.laneFinish[i]) begin
                state_d[i] = LANE_HELD;
                err_d[i]   = bus.laneError[i*ErrorWidth +: ErrorWidth];
            end
        end

        if (emit) begin
            state_d[headLane] = LANE_IDLE;
            outValid_d        = 1'b1;
            outInd_d          = ind_q[headLane];
            outErr_d          = headErr;
            head_d            = (head_q == IdxW'(Lanes - 1)) ? '0 : head_q + 1'b1;
            if (headErr < bestErr_q) begin
                bestErr_d = headErr;
                bestInd_d = ind_q[headLane];
            end
            emitCnt_d = emitCnt_q + 1'b1;
            if (emitCnt_q == {CntW{1'b1}} && gen_q != {GenerationWidth{1'b1}}) begin
                gen_d = gen_q + 1'b1;
            end
            if (headErr <= targetError) begin
                done_d = 1'b1;
            end
        end

        if (accept) begin
            state_d[freeIdx]     = LANE_RUN;
            ind_d[freeIdx]       = bus.inIndividual;
            laneStart_d[freeIdx] = 1'b1;
            ord_d[tail_q]        = freeIdx;
            tail_d               = (tail_q == IdxW'(Lanes - 1)) ? '0 : tail_q + 1'b1;
        end

        if (accept && !emit) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && emit) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Lanes; i++) begin
                state_q[i] <= LANE_IDLE;
                ind_q[i]   <= '0;
                err_q[i]   <= '0;
                ord_q[i]   <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            laneStart_q <= '0;
            outValid_q  <= 1'b0;
            outInd_q    <= '0;
            outErr_q    <= '0;
            bestInd_q   <= '0;
            bestErr_q   <= '1;
            gen_q       <= '0;
            emitCnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ind_q       <= ind_d;
            err_q       <= err_d;
            ord_q       <= ord_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            laneStart_q <= laneStart_d;
            outValid_q  <= outValid_d;
            outInd_q    <= outInd_d;
            outErr_q    <= outErr_d;
            bestInd_q   <= bestInd_d;
            bestErr_q   <= bestErr_d;
            gen_q       <= gen_d;
            emitCnt_q   <= emitCnt_d;
            done_q      <= done_d;
        end
    end

    for (genvar g = 0; g < Lanes; g++) begin : g_lane
        assign bus.laneIndividual[g*IndividualWidth +: IndividualWidth] = ind_q[g];
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < Lanes; i++) begin
            if (state_q[i] != LANE_IDLE) begin
                busy = 1'b1;
            end
        end
    end

    assign bus.laneStart     = laneStart_q;
    assign bus.outValid      = outValid_q;
    assign bus.outIndividual = outInd_q;
    assign bus.outError      = outErr_q;
    assign bestIndividual    = bestInd_q;
    assign bestError         = bestErr_q;
    assign generation        = gen_q;
    assign done              = done_q;
endmodule
`default_nettype wire

// File: doc/parallel_fitness_dispatcher.md
PARALLEL_FITNESS_DISPATCHER -- requirements
Module: parallel_fitness_dispatcher

Interface
REQ-001 SHALL have parameter IndividualWidth, default 64, individual (instruction word) width in bits.
REQ-002 SHALL have parameter ErrorWidth, default 5, fitness error width in bits.
REQ-003 SHALL have parameter Lanes, default 4, number of parallel fitness evaluators (1..16).
REQ-004 SHALL have parameter GenerationSize, default 16, results per generation (power of two, >= 2).
REQ-005 SHALL have parameter GenerationWidth, default 16, generation counter width.
REQ-006 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1, permits acceptance of new individuals.
REQ-009 SHALL have port targetError, input, ErrorWidth, early-stop threshold.
REQ-010 SHALL have ports inValid (input, 1), inReady (output, 1) and inIndividual (input, IndividualWidth), which form the individual-request handshake from the GA core.
REQ-011 SHALL have ports outValid (output, 1), outIndividual (output, IndividualWidth) and outError (output, ErrorWidth), which form the result pulse to the GA core.
REQ-012 SHALL have ports laneStart (output, Lanes) and laneIndividual (output, Lanes*IndividualWidth), which drive the evaluators.
REQ-013 SHALL have ports laneFinish (input, Lanes) and laneError (input, Lanes*ErrorWidth), which carry the evaluator results.
REQ-014 SHALL have ports bestIndividual (output, IndividualWidth), bestError (output, ErrorWidth), generation (output, GenerationWidth), done (output, 1) and busy (output, 1).

Function
REQ-015 SHALL keep each lane in exactly one of three states: IDLE, RUN or HELD. IDLE->RUN occurs on dispatch, RUN->HELD on laneFinish, and HELD->IDLE on emission of the lane's result.
REQ-016 SHALL drive inReady = enable && !done && (at least one lane IDLE), combinationally.
REQ-017 SHALL dispatch an accepted individual (inValid && inReady at an edge) to the lowest-index IDLE lane, register it into that lane's laneIndividual slice, and push the lane index into the order queue (depth Lanes).
REQ-018 SHALL pulse laneStart[i] high for exactly one cycle, in the cycle after acceptance; laneIndividual slice i SHALL stay stable until lane i returns to IDLE.
REQ-019 SHALL sample laneFinish[i] only while lane i is in RUN, capturing laneError slice i on that edge; laneFinish in IDLE or HELD SHALL be ignored.
REQ-020 SHALL emit results strictly in acceptance order: when the lane at the head of the order queue is HELD, it drives outValid high for one cycle with that lane's individual and error, pops the queue, and frees the lane. At most one emission occurs per cycle.
REQ-021 SHALL give minimum latency as follows: laneFinish sampled at edge F with its lane at the queue head gives outValid high in the cycle after F.
REQ-022 SHALL allow acceptance and emission in the same cycle; a lane freed in cycle N SHALL first be dispatchable in cycle N+1.
REQ-023 SHALL have no backpressure on the output side; outValid is a pulse.
REQ-024 SHALL update bestIndividual/bestError on each emission only if outError < bestError (strict; ties keep the earlier result).
REQ-025 SHALL count emissions modulo GenerationSize; on wrap, generation SHALL increment by 1 and saturate at all-ones.
REQ-026 SHALL set done on the edge of an emission with outError <= targetError; done SHALL stay sticky until reset.
REQ-027 After done, acceptance SHALL stop, but in-flight lanes SHALL still finish and emit, and best tracking SHALL continue.
REQ-028 When enable is low, acceptance SHALL stop only; RUN/HELD lanes and emission SHALL be unaffected.
REQ-029 SHALL drive busy = any lane not IDLE.

Reset
REQ-030 On rst low, all state SHALL clear asynchronously: all lanes IDLE, queue empty, laneStart=0, laneIndividual=0, outValid=0, outIndividual=0, outError=0, bestIndividual=0, bestError=all-ones, generation=0, emission count=0, done=0.
REQ-031 Reset asserted mid-evaluation SHALL discard all in-flight results; a laneFinish arriving after reset release for a discarded job SHALL be ignored (its lane is IDLE).

Verification
REQ-032 Lanes=4, enable=1, inValid held high with individuals A,B,C,D -> dispatched to lanes 0,1,2,3 on consecutive edges; inReady=0 once all four lanes are RUN; laneStart pulses are one-hot and each one cycle wide.
REQ-033 Out-of-order finish: lane 2 (error 7) finishes before lane 0 (error 3) -> no outValid until lane 0 finishes; then outputs are emitted in the order A(3), B, C(7), one per cycle.
REQ-034 Best tracking: emitted errors 9,4,4,6 -> bestError sequence 9,4,4,4, with bestIndividual equal to the second individual.
REQ-035 targetError=2, emitted errors 5,2 -> done=1 after the second emission and inReady=0; remaining RUN lanes still emit, and done stays 1.
REQ-036 GenerationSize=4: 9 emissions -> generation=2; rst pulsed low mid-run -> all outputs equal their REQ-030 values immediately, and a later stale laneFinish produces no outValid.
